// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   state_t      : sequencer FSM state encoding
//   PC_W_DEF     : default program-counter width (D)
//   CYC_W_DEF    : default cycle-counter width (CW)
//   RSTACK_DEPTH : return-address stack depth (PC_SEQ_CALL_STACK_EN builds)
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RELOAD = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned PC_W_DEF     = 12;
    localparam int unsigned CYC_W_DEF    = 16;
    localparam int unsigned RSTACK_DEPTH = 4;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack.
// Ports: clk, reset (sync, active-high), push/din write the top entry,
//        pop removes it; dout shows the current top (0 when empty);
//        full/empty flags. A push when full or a pop when empty is ignored.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned W     = PC_W_DEF,
    parameter int unsigned DEPTH = RSTACK_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [CNTW-1:0] r_cnt;

    assign full  = (r_cnt == CNTW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign dout  = empty ? '0 : r_mem[AW'(r_cnt - CNTW'(1))];

    // r_cnt is the number of valid entries; the top lives at r_cnt-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !full) begin
            r_mem[AW'(r_cnt)] <= din;
            r_cnt             <= r_cnt + CNTW'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives PC hold / relative / absolute jump
// controls from an IDLE -> RELOAD -> RUN -> DONE FSM and counts RUN cycles.
// Ports: clk, reset (sync, active-high); go, stall, halt, br_valid, br_abs,
//        br_taken, br_target, prog_ctr in; pc_hold, rel_en, abs_en,
//        pc_target, busy, done, cycles out (PC controls are combinational).
// Option: define PC_SEQ_CALL_STACK_EN to add call/ret inputs, a sticky err
//         output and a return-address stack (ret_stack).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D  = PC_W_DEF,
    parameter int unsigned CW = CYC_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          stall,
    input  logic          halt,
    input  logic          br_valid,
    input  logic          br_abs,
    input  logic          br_taken,
    input  logic [D-1:0]  br_target,
    input  logic [D-1:0]  prog_ctr,
    output logic          pc_hold,
    output logic          rel_en,
    output logic          abs_en,
    output logic [D-1:0]  pc_target,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycles
`ifdef PC_SEQ_CALL_STACK_EN
    ,
    input  logic          call,
    input  logic          ret,
    output logic          err
`endif
);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cycles;

`ifdef PC_SEQ_CALL_STACK_EN
    logic         w_push;
    logic         w_pop;
    logic         w_err_set;
    logic [D-1:0] w_top;
    logic         w_full;
    logic         w_empty;
    logic         r_err;

    ret_stack #(.W(D), .DEPTH(RSTACK_DEPTH)) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (D'(prog_ctr + D'(1))),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    // Overflow/underflow flag, sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // prog_ctr only feeds the return-address stack
    logic w_unused_prog_ctr;
    assign w_unused_prog_ctr = ^prog_ctr;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and PC controls; priority in RUN: stall > halt > ret > branch
    always_comb begin
        w_next    = r_state;
        pc_hold   = 1'b0;
        rel_en    = 1'b0;
        abs_en    = 1'b0;
        pc_target = '0;
`ifdef PC_SEQ_CALL_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                pc_hold = 1'b1;
                if (go) begin
                    w_next = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                abs_en = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    pc_hold = 1'b1;
                end else if (halt) begin
                    pc_hold = 1'b1;
                    w_next  = ST_DONE;
                end
`ifdef PC_SEQ_CALL_STACK_EN
                // Empty-stack return falls through so the PC just increments
                else if (ret) begin
                    if (w_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        abs_en    = 1'b1;
                        pc_target = w_top;
                    end
                end
`endif
                else if (br_valid && br_taken) begin
                    pc_target = br_target;
                    if (br_abs) begin
                        abs_en = 1'b1;
`ifdef PC_SEQ_CALL_STACK_EN
                        // Call on a full stack still jumps; the push is dropped
                        if (call) begin
                            if (w_full) begin
                                w_err_set = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
`endif
                    end else begin
                        rel_en = 1'b1;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Cycle counter: cleared entering RELOAD, saturating count in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_next == ST_RELOAD && r_state != ST_RELOAD) begin
            r_cycles <= '0;
        end else if (r_state == ST_RUN && r_cycles != '1) begin
            r_cycles <= r_cycles + CW'(1);
        end
    end

    assign cycles = r_cycles;
    assign busy   = (r_state == ST_RELOAD) || (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of single-cycle RUN vectors plus
// hand-written sequences for reload, halt, restart, saturation and reset.
module tb_pc_sequencer;

    localparam int unsigned D  = 12;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_abs = 1'b0;
    logic          br_taken = 1'b0;
    logic [D-1:0]  br_target = '0;
    logic [D-1:0]  prog_ctr = '0;
    logic          pc_hold;
    logic          rel_en;
    logic          abs_en;
    logic [D-1:0]  pc_target;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles;
`ifdef PC_SEQ_CALL_STACK_EN
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          err;
`endif

    int total = 0;
    int bad = 0;
    int exp_cyc = 0;

    pc_sequencer #(.D(D), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .stall     (stall),
        .halt      (halt),
        .br_valid  (br_valid),
        .br_abs    (br_abs),
        .br_taken  (br_taken),
        .br_target (br_target),
        .prog_ctr  (prog_ctr),
        .pc_hold   (pc_hold),
        .rel_en    (rel_en),
        .abs_en    (abs_en),
        .pc_target (pc_target),
        .busy      (busy),
        .done      (done),
        .cycles    (cycles)
`ifdef PC_SEQ_CALL_STACK_EN
        ,
        .call      (call),
        .ret       (ret),
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         stall;
        logic         halt;
        logic         bv;
        logic         ba;
        logic         bt;
        logic [D-1:0] tgt;
        logic         e_hold;
        logic         e_rel;
        logic         e_abs;
        logic [D-1:0] e_tgt;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_pc(input string tag, input logic h, input logic r, input logic a,
                          input logic [D-1:0] t);
        chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(h));
        chk({tag, ".rel_en"}, 32'(rel_en), 32'(r));
        chk({tag, ".abs_en"}, 32'(abs_en), 32'(a));
        chk({tag, ".pc_target"}, 32'(pc_target), 32'(t));
    endtask

    task automatic clr_in();
        go = 1'b0; stall = 1'b0; halt = 1'b0;
        br_valid = 1'b0; br_abs = 1'b0; br_taken = 1'b0;
        br_target = '0; prog_ctr = '0;
`ifdef PC_SEQ_CALL_STACK_EN
        call = 1'b0; ret = 1'b0;
`endif
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the saturating RUN-cycle counter, stepped per RUN edge
    task automatic run_tick();
        tick();
        if (exp_cyc < (1 << CW) - 1) exp_cyc++;
    endtask

    initial begin
        //            stall halt bv ba bt tgt      hold rel abs e_tgt
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b1, 1'b0, 12'hFFE};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0, 1'b0, 1'b0, 12'h000};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b1, 1'b0, 1'b0, 12'h000};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 1'b0, 1'b1, 12'h040};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 12'h000};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 12'hFFF};
        vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h055, 1'b1, 1'b0, 1'b0, 12'h000};
        vt[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0, 12'h001};

        // Reset state
        clr_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_pc("rst", 1'b1, 1'b0, 1'b0, 12'h000);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.cycles", 32'(cycles), 32'd0);

        // IDLE without go stays idle
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        // go -> RELOAD; branch/stall/halt ignored there
        go = 1'b1;
        tick();
        go = 1'b0;
        stall = 1'b1; halt = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 12'h0AA;
        #1;
        chk_pc("reload", 1'b0, 1'b0, 1'b1, 12'h000);
        chk("reload.busy", 32'(busy), 32'd1);
        chk("reload.cycles", 32'(cycles), 32'd0);
        tick();
        clr_in();
        exp_cyc = 0;
        #1;
        chk_pc("run0", 1'b0, 1'b0, 1'b0, 12'h000);
        chk("run0.busy", 32'(busy), 32'd1);
        chk("run0.done", 32'(done), 32'd0);

        // Single-cycle RUN vectors
        for (int i = 0; i < 10; i++) begin
            stall = vt[i].stall; halt = vt[i].halt;
            br_valid = vt[i].bv; br_abs = vt[i].ba; br_taken = vt[i].bt;
            br_target = vt[i].tgt;
            // vector 8 mixes halt with stall: stall suppresses the halt
            #1;
            chk_pc($sformatf("vec%0d", i), vt[i].e_hold, vt[i].e_rel, vt[i].e_abs, vt[i].e_tgt);
            chk($sformatf("vec%0d.cycles", i), 32'(cycles), 32'(exp_cyc));
            run_tick();
            clr_in();
        end
        chk("vec.still_run", 32'(busy), 32'd1);

        // go ignored in RUN
        go = 1'b1;
        run_tick();
        go = 1'b0;
        #1;
        chk("run_go.busy", 32'(busy), 32'd1);
        chk("run_go.cycles", 32'(cycles), 32'(exp_cyc));

        // halt wins over a taken branch
        halt = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_abs = 1'b1; br_target = 12'h040;
        #1;
        chk_pc("halt", 1'b1, 1'b0, 1'b0, 12'h000);
        run_tick();
        clr_in();
        #1;
        chk("done.done", 32'(done), 32'd1);
        chk("done.busy", 32'(busy), 32'd0);
        chk_pc("done", 1'b1, 1'b0, 1'b0, 12'h000);
        chk("done.cycles", 32'(cycles), 32'(exp_cyc));
        tick();
        tick();
        chk("done.frozen", 32'(cycles), 32'(exp_cyc));

        // Restart from DONE clears cycles
        go = 1'b1;
        tick();
        go = 1'b0;
        #1;
        chk_pc("restart", 1'b0, 1'b0, 1'b1, 12'h000);
        chk("restart.cycles", 32'(cycles), 32'd0);
        chk("restart.done", 32'(done), 32'd0);
        tick();
        exp_cyc = 0;

        // Saturation of the cycle counter
        for (int i = 0; i < 20; i++) run_tick();
        chk("sat.cycles", 32'(cycles), 32'(exp_cyc));
        chk("sat.allones", 32'(cycles), 32'((1 << CW) - 1));

        // Reset mid-RUN with stall
        stall = 1'b1; br_valid = 1'b1; br_taken = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_in();
        #1;
        chk_pc("rst_run", 1'b1, 1'b0, 1'b0, 12'h000);
        chk("rst_run.cycles", 32'(cycles), 32'd0);
        chk("rst_run.done", 32'(done), 32'd0);
        chk("rst_run.busy", 32'(busy), 32'd0);

`ifdef PC_SEQ_CALL_STACK_EN
        chk("stk.err0", 32'(err), 32'd0);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        // Five calls: pushes 0x011..0x014 kept, the fifth overflows
        for (int i = 0; i < 5; i++) begin
            br_valid = 1'b1; br_taken = 1'b1; br_abs = 1'b1; call = 1'b1;
            br_target = 12'h100; prog_ctr = 12'(12'h010 + i);
            #1;
            chk($sformatf("call%0d.abs", i), 32'(abs_en), 32'd1);
            chk($sformatf("call%0d.err", i), 32'(err), 32'd0);
            tick();
        end
        clr_in();
        #1;
        chk("stk.err_ovf", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            #1;
            chk($sformatf("ret%0d.abs", i), 32'(abs_en), 32'd1);
            chk($sformatf("ret%0d.tgt", i), 32'(pc_target), 32'(12'h014 - i));
            tick();
        end
        // Pop on empty falls through
        ret = 1'b1;
        #1;
        chk_pc("ret_empty", 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        clr_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("stk.err_rst", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 12: program-counter width in bits.
REQ-002 Parameter CW, default 16: cycle-counter width in bits.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go  input  1  single-cycle request to (re)start program execution.
REQ-006 stall  input  1  fetch/datapath wait; freezes the PC this cycle.
REQ-007 halt  input  1  decoded halt instruction at the current PC.
REQ-008 br_valid  input  1  decoded branch at the current PC.
REQ-009 br_abs  input  1  1 = absolute branch, 0 = PC-relative branch.
REQ-010 br_taken  input  1  branch condition is met.
REQ-011 br_target  input  D  branch address (absolute) or offset (relative, two's complement).
REQ-012 prog_ctr  input  D  current PC value, used for the call return address.
REQ-013 pc_hold  output  1  freezes the PC (PC hold input).
REQ-014 rel_en  output  1  PC relative-jump enable.
REQ-015 abs_en  output  1  PC absolute-jump enable.
REQ-016 pc_target  output  D  PC jump operand.
REQ-017 busy  output  1  high in RELOAD and RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 cycles  output  CW  execution cycle count.

Function
REQ-020 The FSM SHALL have the states IDLE, RELOAD, RUN and DONE; outputs SHALL be combinational from the state and the current inputs.
REQ-021 IDLE and DONE SHALL drive pc_hold=1, rel_en=0, abs_en=0; go SHALL move to RELOAD on the next edge.
REQ-022 RELOAD SHALL last exactly one cycle with pc_hold=0, abs_en=1, pc_target=0, then move to RUN; stall, halt and branch inputs SHALL be ignored in RELOAD.
REQ-023 In RUN, stall=1 SHALL force pc_hold=1 and rel_en=abs_en=0, and SHALL suppress halt and branch decisions that cycle.
REQ-024 In RUN with stall=0 and halt=1, the block SHALL drive pc_hold=1, move to DONE next edge, and ignore any branch that cycle (halt wins).
REQ-025 In RUN with stall=0, halt=0, br_valid=1 and br_taken=1: br_abs=1 SHALL drive abs_en=1; br_abs=0 SHALL drive rel_en=1. pc_target SHALL equal br_target in both cases.
REQ-026 In RUN with no stall, halt or taken branch, all three PC controls SHALL be 0 so the PC increments.
REQ-027 rel_en and abs_en SHALL never be high together; pc_target SHALL be 0 whenever neither is high.
REQ-028 go SHALL be ignored in RELOAD and RUN; in DONE it SHALL restart via RELOAD.
REQ-029 cycles SHALL clear on entry to RELOAD, increment once per RUN cycle (stalled cycles included), saturate at all-ones, and hold in IDLE and DONE.

Reset
REQ-030 reset SHALL take priority over all inputs and force IDLE, cycles=0, busy=0, done=0, with the stack emptied and err cleared when PC_SEQ_CALL_STACK_EN is defined.
REQ-031 Reset asserted mid-RUN SHALL take effect at the next edge regardless of stall, halt or branch.

Configuration
REQ-032 Macro PC_SEQ_CALL_STACK_EN SHALL add inputs call and ret (1 bit each) and output err (1 bit), plus a 4-entry return-address stack.
REQ-033 With the macro defined: a taken absolute branch with call=1 SHALL push prog_ctr+1 (mod 2^D). ret=1 in RUN without stall SHALL pop and drive abs_en=1 with pc_target equal to the popped value. halt SHALL override call/ret.
REQ-034 A push when full SHALL be dropped. A pop when empty SHALL fall through (PC increments). Both cases SHALL set err sticky until reset.
REQ-035 Without the macro, the call, ret and err ports and the stack SHALL not exist, and behaviour SHALL be REQ-020 to REQ-031 only.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum type, the default D, and the constant RSTACK_DEPTH=4.
REQ-037 Sub-module ret_stack (push/pop/full/empty, LIFO) SHALL hold the return addresses and SHALL be instantiated only under PC_SEQ_CALL_STACK_EN.

Verification
REQ-038 reset, then go pulse -> next cycle RELOAD with abs_en=1, pc_target=0; following cycle busy=1, all PC controls 0.
REQ-039 RUN, br_valid=1, br_taken=1, br_abs=0, br_target=12'hFFE -> rel_en=1, pc_target=12'hFFE; with br_taken=0 -> all controls 0.
REQ-040 RUN, stall=1 together with a taken abs branch to 12'h040 -> pc_hold=1, abs_en=0; branch honoured on the first unstalled cycle.
REQ-041 halt=1 with a taken branch in the same cycle -> pc_hold=1, no jump; next cycle done=1, cycles frozen; go -> RELOAD and cycles=0.
REQ-042 Macro on: five calls from prog_ctr=12'h010..12'h014 -> 4 pushes kept, err=1; four rets -> targets 12'h014, 12'h013, 12'h012, 12'h011.
REQ-043 reset asserted during RUN with stall=1 -> next cycle IDLE, pc_hold=1, cycles=0, done=0.
